// File: rtl/kronos_types.sv
// kronos_types
//   Shared types for the kronos instruction fetch path.
//   - ifetch_req_t : request bundle driven towards instruction memory (mem_req/mem_addr)
//   - ifetch_rsp_t : response bundle returned by instruction memory (mem_gnt/mem_rvalid/mem_rdata)
//   - next_word()  : sequential word address, wraps modulo 2^32
package kronos_types;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
    } ifetch_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } ifetch_rsp_t;

    localparam logic [31:0] WORD_STEP = 32'd4;

    function automatic logic [31:0] next_word(input logic [31:0] pc);
        return pc + WORD_STEP;
    endfunction

endpackage

// File: rtl/kronos_prefetch_fifo.sv
// kronos_prefetch_fifo
//   DEPTH x 32 synchronous FIFO holding prefetched instruction words.
//   Ports:
//     clk, rstz     clock, asynchronous active-low reset
//     flush         drop all entries (wins over push/pop)
//     push, push_data
//     pop           remove head entry (caller guarantees count>0)
//     head_data     oldest entry, read straight from the storage registers
//     count         number of valid entries, 0..DEPTH
//   Push and pop together while full is legal: the write lands in the slot
//   the pop is vacating.
module kronos_prefetch_fifo #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rstz,
    input  logic          flush,
    input  logic          push,
    input  logic [31:0]   push_data,
    input  logic          pop,
    output logic [31:0]   head_data,
    output logic [CW-1:0] count
);

    localparam int PW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/kronos_prefetch.sv
// kronos_prefetch
//   Instruction prefetch buffer between the core fetch port and a pipelined
//   instruction memory. Sequential words are requested ahead of the core and
//   buffered; a core request matching the buffer head is acked from the
//   buffer in the same cycle. A request for any other address redirects the
//   stream and marks every response still in flight as stale.
//   Ports:
//     clk, rstz                 clock, asynchronous active-low reset
//     instr_addr/instr_req      core fetch request (held until instr_ack)
//     instr_data/instr_ack      buffered word and its 1-cycle ack
//     mem_addr/mem_req          memory request (may drop before grant)
//     mem_gnt                   request accepted this cycle
//     mem_rdata/mem_rvalid      in-order response for oldest granted request
//   Handshakes: mem side transfers a request when mem_req & mem_gnt in the
//   same cycle; one response per grant arrives later with mem_rvalid. Core
//   side transfers when instr_ack is high; instr_ack depends only on core
//   inputs and registered state, never on mem_* inputs.
module kronos_prefetch
    import kronos_types::*;
#(
    parameter logic [31:0] BOOT_ADDR       = 32'h0,
    parameter int          DEPTH           = 4,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic [31:0] instr_addr,
    input  logic        instr_req,
    output logic [31:0] instr_data,
    output logic        instr_ack,
    output logic [31:0] mem_addr,
    output logic        mem_req,
    input  logic        mem_gnt,
    input  logic [31:0] mem_rdata,
    input  logic        mem_rvalid
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    ifetch_req_t   mem_o;
    ifetch_rsp_t   mem_i;

    logic [31:0]   head_pc_q, head_pc_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [OW-1:0] inflight_q, inflight_d;
    logic [OW-1:0] drop_q, drop_d;

    logic [CW-1:0] fifo_count;
    logic [31:0]   fifo_head;
    logic          fifo_push;
    logic          fifo_flush;

    logic          head_match;
    logic          redirect;
    logic          hit;
    logic          rsp_fire;
    logic          gnt_fire;
    logic          issue;
    logic [31:0]   live;
    logic          credit_ok;

    assign mem_i = '{gnt: mem_gnt, rvalid: mem_rvalid, rdata: mem_rdata};

    always_comb begin
        head_match = (instr_addr == head_pc_q);
        redirect   = rstz & instr_req & ~head_match;
        hit        = rstz & instr_req & head_match & (fifo_count != '0);
        // A response with nothing outstanding is a memory protocol error; ignore it.
        rsp_fire   = mem_i.rvalid & (inflight_q != '0);
        // Only non-stale outstanding requests will ever occupy FIFO slots.
        live       = 32'(inflight_q) - 32'(drop_q);
        credit_ok  = (32'(fifo_count) + live) < 32'(DEPTH);
        issue      = rstz & ~redirect & credit_ok & (32'(inflight_q) < 32'(MAX_OUTSTANDING));
        gnt_fire   = issue & mem_i.gnt;
    end

    always_comb begin
        head_pc_d  = head_pc_q;
        fetch_pc_d = fetch_pc_q;
        inflight_d = inflight_q;
        drop_d     = drop_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;

        case ({gnt_fire, rsp_fire})
            2'b10:   inflight_d = inflight_q + OW'(1);
            2'b01:   inflight_d = inflight_q - OW'(1);
            default: inflight_d = inflight_q;
        endcase

        if (redirect) begin
            fifo_flush = 1'b1;
            head_pc_d  = instr_addr;
            fetch_pc_d = instr_addr;
            // Everything still outstanding after this cycle belongs to the old stream.
            drop_d     = rsp_fire ? (inflight_q - OW'(1)) : inflight_q;
        end else begin
            if (gnt_fire) begin
                fetch_pc_d = next_word(fetch_pc_q);
            end
            if (hit) begin
                head_pc_d = next_word(head_pc_q);
            end
            if (rsp_fire) begin
                if (drop_q != '0) begin
                    drop_d = drop_q - OW'(1);
                end else begin
                    fifo_push = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            head_pc_q  <= BOOT_ADDR;
            fetch_pc_q <= BOOT_ADDR;
            inflight_q <= '0;
            drop_q     <= '0;
        end else begin
            head_pc_q  <= head_pc_d;
            fetch_pc_q <= fetch_pc_d;
            inflight_q <= inflight_d;
            drop_q     <= drop_d;
        end
    end

    kronos_prefetch_fifo #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rstz      (rstz),
        .flush     (fifo_flush),
        .push      (fifo_push),
        .push_data (mem_i.rdata),
        .pop       (hit),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    assign mem_o.req  = issue;
    assign mem_o.addr = fetch_pc_q;
    assign mem_req    = mem_o.req;
    assign mem_addr   = mem_o.addr;
    assign instr_ack  = hit;
    assign instr_data = fifo_head;

    a_no_stray_rvalid : assert property (@(posedge clk) disable iff (!rstz)
        mem_rvalid |-> (inflight_q != '0));

endmodule

// File: tb/tb_kronos_prefetch.sv
// tb_kronos_prefetch
//   Directed bench for kronos_prefetch (BOOT_ADDR=0, DEPTH=4, MAX_OUTSTANDING=2).
//   The memory model grants when told to, queues granted addresses, and
//   returns them in order one per cycle unless held; word at address A is
//   A ^ 32'hC0DE_5A00. Inputs change on the falling edge, outputs are
//   sampled 1 time unit later, the DUT clocks on the rising edge.
module tb_kronos_prefetch;

    logic        clk = 1'b0;
    logic        rstz;
    logic [31:0] instr_addr;
    logic        instr_req;
    logic [31:0] instr_data;
    logic        instr_ack;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;

    int          errors = 0;
    int          checks = 0;

    logic [31:0] pend_q[$];
    logic        s_ack;
    logic        s_mreq;
    logic [31:0] s_data;
    logic [31:0] s_maddr;

    typedef struct {
        logic        rst;
        logic        req;
        logic [31:0] addr;
        logic        gnt;
        logic        hold;
        logic        ack;
        logic [31:0] data;
        logic        mreq;
        logic [31:0] maddr;
    } vec_t;

    vec_t vecs[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    kronos_prefetch #(
        .BOOT_ADDR       (32'h0),
        .DEPTH           (4),
        .MAX_OUTSTANDING (2)
    ) dut (
        .clk        (clk),
        .rstz       (rstz),
        .instr_addr (instr_addr),
        .instr_req  (instr_req),
        .instr_data (instr_data),
        .instr_ack  (instr_ack),
        .mem_addr   (mem_addr),
        .mem_req    (mem_req),
        .mem_gnt    (mem_gnt),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid)
    );

    function automatic logic [31:0] w(input logic [31:0] a);
        return a ^ 32'hC0DE_5A00;
    endfunction

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " instr_ack"},  32'(instr_ack), 32'h0);
        check({name, " mem_req"},    32'(mem_req),   32'h0);
        check({name, " mem_addr"},   mem_addr,       32'h0);
        check({name, " instr_data"}, instr_data,     32'h0);
    endtask

    // ---------------- drivers ----------------
    task automatic do_reset();
        rstz       = 1'b0;
        instr_req  = 1'b0;
        instr_addr = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        pend_q.delete();
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rstz = 1'b1;
    endtask

    // One cycle: drive inputs at the falling edge, sample, update memory model.
    task automatic tick(input logic req, input logic [31:0] addr, input logic gnt, input logic hold);
        instr_req  = req;
        instr_addr = addr;
        mem_gnt    = gnt;
        if (pend_q.size() != 0 && !hold) begin
            mem_rvalid = 1'b1;
            mem_rdata  = w(pend_q[0]);
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata  = 32'h0;
        end
        #1;
        s_ack   = instr_ack;
        s_data  = instr_data;
        s_mreq  = mem_req;
        s_maddr = mem_addr;
        if (mem_rvalid) void'(pend_q.pop_front());
        if (s_mreq && gnt) pend_q.push_back(s_maddr);
        @(negedge clk);
    endtask

    task automatic step(input string name,
                        input logic req, input logic [31:0] addr, input logic gnt, input logic hold,
                        input logic ack, input logic [31:0] data, input logic mreq, input logic [31:0] maddr);
        tick(req, addr, gnt, hold);
        check({name, " instr_ack"}, 32'(s_ack), 32'(ack));
        if (ack) check({name, " instr_data"}, s_data, data);
        check({name, " mem_req"},  32'(s_mreq), 32'(mreq));
        check({name, " mem_addr"}, s_maddr, maddr);
    endtask

    task automatic add(input logic rst, input logic req, input logic [31:0] addr, input logic gnt,
                       input logic hold, input logic ack, input logic [31:0] data, input logic mreq,
                       input logic [31:0] maddr);
        vec_t v;
        v.rst = rst; v.req = req; v.addr = addr; v.gnt = gnt; v.hold = hold;
        v.ack = ack; v.data = data; v.mreq = mreq; v.maddr = maddr;
        vecs.push_back(v);
    endtask

    initial begin
        // Streaming from reset: req/gnt in cycle 1, rvalid cycle 2, first ack cycle 3.
        add(1, 1, 32'h00, 1, 0, 0, 32'h0,   1, 32'h00);
        add(0, 1, 32'h00, 1, 0, 0, 32'h0,   1, 32'h04);
        add(0, 1, 32'h00, 1, 0, 1, w(32'h00), 1, 32'h08);
        add(0, 1, 32'h04, 1, 0, 1, w(32'h04), 1, 32'h0C);
        add(0, 1, 32'h08, 1, 0, 1, w(32'h08), 1, 32'h10);
        add(0, 1, 32'h0C, 1, 0, 1, w(32'h0C), 1, 32'h14);
        // Core held off until the buffer fills, then drained.
        add(1, 0, 32'h00, 1, 0, 0, 32'h0,   1, 32'h00);
        add(0, 0, 32'h00, 1, 0, 0, 32'h0,   1, 32'h04);
        add(0, 0, 32'h00, 1, 0, 0, 32'h0,   1, 32'h08);
        add(0, 0, 32'h00, 1, 0, 0, 32'h0,   1, 32'h0C);
        add(0, 0, 32'h00, 1, 0, 0, 32'h0,   0, 32'h10);
        add(0, 0, 32'h00, 1, 0, 0, 32'h0,   0, 32'h10);
        add(0, 1, 32'h00, 1, 0, 1, w(32'h00), 0, 32'h10);
        add(0, 0, 32'h00, 1, 0, 0, 32'h0,   1, 32'h10);
        add(0, 0, 32'h00, 1, 0, 0, 32'h0,   0, 32'h14);
        add(0, 1, 32'h04, 1, 0, 1, w(32'h04), 0, 32'h14);
        add(0, 1, 32'h08, 1, 0, 1, w(32'h08), 1, 32'h14);
        add(0, 1, 32'h0C, 1, 0, 1, w(32'h0C), 1, 32'h18);
        add(0, 1, 32'h10, 1, 0, 1, w(32'h10), 1, 32'h1C);

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].rst) do_reset();
            step($sformatf("vec%0d", i), vecs[i].req, vecs[i].addr, vecs[i].gnt, vecs[i].hold,
                 vecs[i].ack, vecs[i].data, vecs[i].mreq, vecs[i].maddr);
        end

        // Redirect with two requests outstanding: both responses are stale.
        do_reset();
        step("redir c1", 0, 32'h000, 1, 1, 0, 32'h0, 1, 32'h000);
        step("redir c2", 0, 32'h000, 1, 1, 0, 32'h0, 1, 32'h004);
        step("redir c3", 1, 32'h100, 1, 1, 0, 32'h0, 0, 32'h008);
        step("redir c4", 1, 32'h100, 1, 0, 0, 32'h0, 0, 32'h100);
        step("redir c5", 1, 32'h100, 1, 0, 0, 32'h0, 1, 32'h100);
        step("redir c6", 1, 32'h100, 1, 0, 0, 32'h0, 1, 32'h104);
        step("redir c7", 1, 32'h100, 1, 0, 1, w(32'h100), 1, 32'h108);
        step("redir c8", 1, 32'h104, 1, 0, 1, w(32'h104), 1, 32'h10C);

        // Grant withheld for five cycles: request stays put, nothing lost or repeated.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step($sformatf("stall c%0d", i + 1), 1, 32'h0, 0, 0, 0, 32'h0, 1, 32'h0);
        end
        step("stall c6",  1, 32'h0, 1, 0, 0, 32'h0,   1, 32'h00);
        step("stall c7",  1, 32'h0, 1, 0, 0, 32'h0,   1, 32'h04);
        step("stall c8",  1, 32'h0, 1, 0, 1, w(32'h0), 1, 32'h08);
        step("stall c9",  1, 32'h4, 1, 0, 1, w(32'h4), 1, 32'h0C);
        step("stall c10", 1, 32'h8, 1, 0, 1, w(32'h8), 1, 32'h10);

        // Address wrap at the top of the 32-bit space.
        do_reset();
        step("wrap c1", 1, 32'hFFFF_FFF8, 1, 0, 0, 32'h0, 0, 32'h0000_0000);
        step("wrap c2", 1, 32'hFFFF_FFF8, 1, 0, 0, 32'h0, 1, 32'hFFFF_FFF8);
        step("wrap c3", 1, 32'hFFFF_FFF8, 1, 0, 0, 32'h0, 1, 32'hFFFF_FFFC);
        step("wrap c4", 1, 32'hFFFF_FFF8, 1, 0, 1, w(32'hFFFF_FFF8), 1, 32'h0000_0000);
        step("wrap c5", 1, 32'hFFFF_FFFC, 1, 0, 1, w(32'hFFFF_FFFC), 1, 32'h0000_0004);
        step("wrap c6", 1, 32'h0000_0000, 1, 0, 1, w(32'h0000_0000), 1, 32'h0000_0008);

        // Reset asserted mid-stream with words buffered and requests outstanding.
        do_reset();
        step("mrst c1", 0, 32'h0, 1, 1, 0, 32'h0, 1, 32'h00);
        step("mrst c2", 0, 32'h0, 1, 1, 0, 32'h0, 1, 32'h04);
        step("mrst c3", 0, 32'h0, 1, 0, 0, 32'h0, 0, 32'h08);
        step("mrst c4", 0, 32'h0, 1, 1, 0, 32'h0, 1, 32'h08);
        step("mrst c5", 0, 32'h0, 1, 0, 0, 32'h0, 0, 32'h0C);
        step("mrst c6", 0, 32'h0, 1, 1, 0, 32'h0, 1, 32'h0C);
        instr_req  = 1'b1;
        instr_addr = 32'h0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        #1;
        check("mrst pre instr_ack",  32'(instr_ack), 32'h1);
        check("mrst pre instr_data", instr_data, w(32'h0));
        rstz = 1'b0;
        pend_q.delete();
        #1;
        check_reset_outputs("mrst async");
        @(negedge clk);
        rstz = 1'b1;
        step("mrst post c1", 1, 32'h0, 1, 0, 0, 32'h0,   1, 32'h00);
        step("mrst post c2", 1, 32'h0, 1, 0, 0, 32'h0,   1, 32'h04);
        step("mrst post c3", 1, 32'h0, 1, 0, 1, w(32'h0), 1, 32'h08);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
